tpu_scheduler: RTL and testbench

//  Front-end sequencer for the Mini TPU control unit. Buffers 16-bit host instructions in a small FIFO.

---
 rtl/tpu_pkg.sv | 28 ++
 rtl/tpu_scheduler_if.sv | 26 ++
 rtl/tpu_instr_fifo.sv | 51 +++++
 rtl/tpu_scheduler.sv | 132 +++++++++++++
 tb/tb_tpu_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the Mini TPU front-end scheduler: opcodes, opcode field, NOP word, FSM states.
package tpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 14;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_RUN   = 3'd3,
    ST_STORE = 3'd4,
    ST_RESP  = 3'd5
  } sched_state_t;

  function automatic logic [1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/tpu_scheduler_if.sv
// Host-side and control-unit-side signals of the scheduler; slave = scheduler, master = host/control model.
interface tpu_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic [15:0]           in_instr;
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           instr_out;
  logic                  ctrl_rst_n;
  logic [DATA_WIDTH-1:0] array_result;
  logic [DATA_WIDTH-1:0] result_out;
  logic                  result_valid;
  logic                  result_ready;
  logic                  run_done;
  logic                  busy;

  modport slave (
    input  in_instr, in_valid, array_result, result_ready,
    output in_ready, instr_out, ctrl_rst_n, result_out, result_valid, run_done, busy
  );

  modport master (
    output in_instr, in_valid, array_result, result_ready,
    input  in_ready, instr_out, ctrl_rst_n, result_out, result_valid, run_done, busy
  );
endinterface

// File: rtl/tpu_instr_fifo.sv
// Synchronous instruction FIFO with first-word-fall-through read port and occupancy count.
module tpu_instr_fifo #(
  parameter int DATA  = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA-1:0]              wr_data,
  input  logic                         pop,
  output logic [DATA-1:0]              rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tpu_scheduler.sv
// Front-end sequencer: queues host instructions and issues them one at a time to the control unit.
module tpu_scheduler
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  tpu_scheduler_if.slave  bus
);
  localparam int RC_W = $clog2(RUN_CYCLES+1);
  localparam int FC_W = $clog2(FIFO_DEPTH+1);
  localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_CYCLES-1);

  sched_state_t          state;
  logic [RC_W-1:0]       run_cnt;
  logic [INSTR_W-1:0]    cur_instr;
  logic [INSTR_W-1:0]    instr_q;
  logic                  ctrl_rst_n_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  result_valid_q;
  logic                  run_done_q;

  logic [INSTR_W-1:0]    fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FC_W-1:0]       fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;

  assign fifo_push = bus.in_valid && !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  tpu_instr_fifo #(
    .DATA  (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (bus.in_instr),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Outputs are loaded on the transition into a state, so they reflect that state while in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      run_cnt        <= '0;
      cur_instr      <= NOP_WORD;
      instr_q        <= NOP_WORD;
      ctrl_rst_n_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      run_done_q     <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          instr_q      <= NOP_WORD;
          ctrl_rst_n_q <= 1'b1;
          if (!fifo_empty) begin
            cur_instr <= fifo_head;
            case (get_opcode(fifo_head))
              OP_LOAD: begin
                instr_q <= fifo_head;
                state   <= ST_LOAD;
              end
              OP_STORE: begin
                instr_q <= fifo_head;
                state   <= ST_STORE;
              end
              OP_RUN: begin
                ctrl_rst_n_q <= 1'b0;
                state        <= ST_CLR;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD: begin
          instr_q <= NOP_WORD;
          state   <= ST_IDLE;
        end
        ST_CLR: begin
          ctrl_rst_n_q <= 1'b1;
          instr_q      <= cur_instr;
          run_cnt      <= '0;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (run_cnt == RUN_LAST) begin
            instr_q    <= NOP_WORD;
            run_done_q <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_STORE: begin
          instr_q        <= NOP_WORD;
          result_q       <= bus.array_result;
          result_valid_q <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          instr_q <= NOP_WORD;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.instr_out    = instr_q;
  assign bus.ctrl_rst_n   = ctrl_rst_n_q;
  assign bus.result_out   = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.run_done     = run_done_q;
  assign bus.busy         = (state != ST_IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_tpu_scheduler.sv
// Directed bench for tpu_scheduler: issue timing, RUN pass, STORE handshake, FIFO full, reset abort, NOP drop.
module tb_tpu_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  tpu_scheduler_if #(.DATA_WIDTH(8)) bus ();

  tpu_scheduler #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .RUN_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_instr     = 16'h0000;
    bus.in_valid     = 1'b0;
    bus.array_result = 8'h00;
    bus.result_ready = 1'b0;
    tick();
    tick();
    check("rst_instr", 32'(bus.instr_out), 32'h0);
    check("rst_ctrl_rst_n", 32'(bus.ctrl_rst_n), 32'h0);
    check("rst_result_out", 32'(bus.result_out), 32'h0);
    check("rst_result_valid", 32'(bus.result_valid), 32'h0);
    check("rst_run_done", 32'(bus.run_done), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();
    check("idle_ctrl_rst_n", 32'(bus.ctrl_rst_n), 32'h1);

    // 1: LOAD appears at t+2 for one cycle
    push(16'h8512);
    check("t1_t1_instr", 32'(bus.instr_out), 32'h0);
    check("t1_t1_busy", 32'(bus.busy), 32'h1);
    tick();
    check("t1_t2_instr", 32'(bus.instr_out), 32'h8512);
    tick();
    check("t1_t3_instr", 32'(bus.instr_out), 32'h0);
    check("t1_t3_busy", 32'(bus.busy), 32'h0);

    // 2: RUN: one CLR cycle, eight RUN cycles, run_done pulse
    push(16'h4000);
    check("t2_t1_ctrl", 32'(bus.ctrl_rst_n), 32'h1);
    tick();
    check("t2_clr_ctrl", 32'(bus.ctrl_rst_n), 32'h0);
    check("t2_clr_instr", 32'(bus.instr_out), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t2_run%0d_instr", i), 32'(bus.instr_out), 32'h4000);
      check($sformatf("t2_run%0d_ctrl", i), 32'(bus.ctrl_rst_n), 32'h1);
      check($sformatf("t2_run%0d_done", i), 32'(bus.run_done), 32'h0);
    end
    tick();
    check("t2_after_instr", 32'(bus.instr_out), 32'h0);
    check("t2_done_pulse", 32'(bus.run_done), 32'h1);
    tick();
    check("t2_done_clear", 32'(bus.run_done), 32'h0);

    // 3: STORE held in RESP; queued LOAD waits for acceptance
    bus.array_result = 8'h5A;
    push(16'hC600);
    bus.in_instr = 16'h8A33;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t3_store_instr", 32'(bus.instr_out), 32'hC600);
    check("t3_store_valid", 32'(bus.result_valid), 32'h0);
    tick();
    bus.array_result = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_resp%0d_valid", i), 32'(bus.result_valid), 32'h1);
      check($sformatf("t3_resp%0d_data", i), 32'(bus.result_out), 32'h5A);
      check($sformatf("t3_resp%0d_instr", i), 32'(bus.instr_out), 32'h0);
      if (i < 4) tick();
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t3_accept_valid", 32'(bus.result_valid), 32'h0);
    check("t3_accept_instr", 32'(bus.instr_out), 32'h0);
    tick();
    check("t3_load_instr", 32'(bus.instr_out), 32'h8A33);
    check("t3_load_valid", 32'(bus.result_valid), 32'h0);
    tick();
    check("t3_load_end", 32'(bus.instr_out), 32'h0);

    // 4: fill FIFO while stalled in RESP
    bus.array_result = 8'h11;
    push(16'hC100);
    tick();
    tick();
    check("t4_resp_valid", 32'(bus.result_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      bus.in_instr = 16'h8100 + 16'(k);
      bus.in_valid = 1'b1;
      check($sformatf("t4_in_ready%0d", k), 32'(bus.in_ready), (k < 4) ? 32'h1 : 32'h0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("t4_full_ready", 32'(bus.in_ready), 32'h0);
    check("t4_result_data", 32'(bus.result_out), 32'h11);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t4_idle_instr", 32'(bus.instr_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t4_issue%0d", k), 32'(bus.instr_out), 32'h8100 + 32'(k));
      if (k == 0) check("t4_ready_after_pop", 32'(bus.in_ready), 32'h1);
      tick();
      check($sformatf("t4_gap%0d", k), 32'(bus.instr_out), 32'h0);
    end
    check("t4_busy_end", 32'(bus.busy), 32'h0);
    tick();
    check("t4_no_fifth", 32'(bus.instr_out), 32'h0);

    // 5: reset during RUN cycle 3 aborts everything
    push(16'h4000);
    tick();
    tick();
    check("t5_run1_instr", 32'(bus.instr_out), 32'h4000);
    bus.in_instr = 16'h8777;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t5_run3_instr", 32'(bus.instr_out), 32'h4000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_instr", 32'(bus.instr_out), 32'h0);
    check("t5_rst_ctrl", 32'(bus.ctrl_rst_n), 32'h0);
    check("t5_rst_done", 32'(bus.run_done), 32'h0);
    check("t5_rst_ready", 32'(bus.in_ready), 32'h1);
    check("t5_rst_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t5_quiet%0d_instr", i), 32'(bus.instr_out), 32'h0);
      check($sformatf("t5_quiet%0d_done", i), 32'(bus.run_done), 32'h0);
    end

    // 6: NOP between LOAD and STORE is dropped
    bus.array_result = 8'h33;
    push(16'h8455);
    bus.in_instr = 16'h0000;
    bus.in_valid = 1'b1;
    tick();
    check("t6_load_instr", 32'(bus.instr_out), 32'h8455);
    bus.in_instr = 16'hC2AA;
    tick();
    bus.in_valid = 1'b0;
    check("t6_gap0", 32'(bus.instr_out), 32'h0);
    tick();
    check("t6_gap1_nop", 32'(bus.instr_out), 32'h0);
    tick();
    check("t6_store_instr", 32'(bus.instr_out), 32'hC2AA);
    tick();
    check("t6_resp_valid", 32'(bus.result_valid), 32'h1);
    check("t6_resp_data", 32'(bus.result_out), 32'h33);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t6_accept_valid", 32'(bus.result_valid), 32'h0);
    tick();
    check("t6_busy_end", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
